// File: rtl/dyn_pattern_gen_if.sv
// Control and serial-stream bundle of the pattern generator.
// master drives the transmission request; slave is the generator itself.
interface dyn_pattern_gen_if #(
   parameter int PAT_W = 8,
   parameter int LEN_W = 4
);
   logic             load;
   logic [PAT_W-1:0] pat_in;
   logic [LEN_W-1:0] pat_len;
   logic [7:0]       rep_cnt;
   logic [7:0]       gap_len;
   logic             abort;
   logic             ready;
   logic             d_out;
   logic             valid_out;
   logic             sent_pulse;
   logic             busy;
   logic             done;

   modport master (
      output load, pat_in, pat_len, rep_cnt, gap_len, abort,
      input  ready, d_out, valid_out, sent_pulse, busy, done
   );

   modport slave (
      input  load, pat_in, pat_len, rep_cnt, gap_len, abort,
      output ready, d_out, valid_out, sent_pulse, busy, done
   );
endinterface

// File: rtl/dyn_pattern_gen.sv
// Serial pattern source: pattern repeated rep_cnt times, each preceded by gap_len LFSR filler bits.
// First bit 1 cycle after load (gap_len+1 with gaps); no backpressure, load taken only while ready=1.
module dyn_pattern_gen #(
   parameter int          PAT_W     = 8,
   parameter int          LEN_W     = 4,
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter bit          GAP_VALID = 1'b1
) (
   input logic              clk,
   input logic              rst,
   dyn_pattern_gen_if.slave bus
);
   typedef enum logic [1:0] {IDLE, GAP, SEND, DONE} st_t;

   typedef struct packed {
      logic [PAT_W-1:0] pat;
      logic [LEN_W-1:0] len;
      logic [7:0]       gap;
   } cfg_t;

   st_t              st, st_n;
   cfg_t             cfg, cfg_n;
   logic [LEN_W-1:0] bit_idx, bit_n, len_clamp;
   logic [7:0]       gap_cnt, gap_n, rep_left, rep_n;
   logic [15:0]      lfsr, lfsr_n;
   logic             d_n, vld_n, sent_n;
   logic             ready_q, d_q, vld_q, sent_q, busy_q, done_q;

   assign len_clamp = (bus.pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.pat_len;

   always_comb begin
      st_n   = st;
      cfg_n  = cfg;
      bit_n  = bit_idx;
      gap_n  = gap_cnt;
      rep_n  = rep_left;
      lfsr_n = lfsr;
      d_n    = 1'b0;
      vld_n  = 1'b0;
      sent_n = 1'b0;
      case (st)
         IDLE: if (bus.load) begin
            cfg_n = '{pat: bus.pat_in, len: len_clamp, gap: bus.gap_len};
            rep_n = bus.rep_cnt;
            if (len_clamp == '0 || bus.rep_cnt == '0) st_n = DONE;
            else if (bus.gap_len != '0) begin
               st_n  = GAP;
               gap_n = bus.gap_len - 8'd1;
            end else begin
               st_n  = SEND;
               bit_n = len_clamp - LEN_W'(1);
            end
         end
         GAP: if (gap_cnt != '0) gap_n = gap_cnt - 8'd1;
              else begin
                 st_n  = SEND;
                 bit_n = cfg.len - LEN_W'(1);
              end
         SEND: if (bit_idx != '0) bit_n = bit_idx - LEN_W'(1);
               else if (rep_left == '0) st_n = DONE;
               else if (cfg.gap != '0) begin
                  st_n  = GAP;
                  gap_n = cfg.gap - 8'd1;
               end else bit_n = cfg.len - LEN_W'(1);
         DONE: st_n = IDLE;
         default: st_n = IDLE;
      endcase
      if (bus.abort && st != IDLE) st_n = IDLE;

      // Outputs describe the cycle being entered so they can leave straight from flops.
      if (st_n == GAP) begin
         d_n    = lfsr[0];
         vld_n  = GAP_VALID;
         lfsr_n = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      end
      if (st_n == SEND) begin
         d_n   = |(cfg_n.pat & (PAT_W'(1) << bit_n));
         vld_n = 1'b1;
         if (bit_n == '0) begin
            sent_n = 1'b1;
            rep_n  = rep_n - 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st       <= IDLE;
         cfg      <= '0;
         bit_idx  <= '0;
         gap_cnt  <= '0;
         rep_left <= '0;
         lfsr     <= SEED;
         ready_q  <= 1'b1;
         d_q      <= 1'b0;
         vld_q    <= 1'b0;
         sent_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         st       <= st_n;
         cfg      <= cfg_n;
         bit_idx  <= bit_n;
         gap_cnt  <= gap_n;
         rep_left <= rep_n;
         lfsr     <= lfsr_n;
         ready_q  <= (st_n == IDLE);
         d_q      <= d_n;
         vld_q    <= vld_n;
         sent_q   <= sent_n;
         busy_q   <= (st_n != IDLE);
         done_q   <= (st_n == DONE);
      end
   end

   assign bus.ready      = ready_q;
   assign bus.d_out      = d_q;
   assign bus.valid_out  = vld_q;
   assign bus.sent_pulse = sent_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
endmodule

// File: tb/tb_dyn_pattern_gen.sv
// Bench for dyn_pattern_gen: directed and randomized transactions scored cycle by cycle
// against a stream-level model (expected bit list per transaction, filler LFSR as a polynomial).
module tb_dyn_pattern_gen;
   localparam int          PAT_W = 8;
   localparam int          LEN_W = 4;
   localparam logic [15:0] SEED  = 16'hACE1;

   typedef struct packed {
      logic vld;
      logic d;
      logic sent;
      logic done;
      logic busy;
      logic ready;
   } smp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          vec_cnt = 0;
   int          err_cnt = 0;
   logic [15:0] m_lfsr = SEED;
   smp_t        exp_q[$];
   smp_t        obs_q[$];

   dyn_pattern_gen_if #(.PAT_W(PAT_W), .LEN_W(LEN_W)) bus ();

   dyn_pattern_gen #(
      .PAT_W(PAT_W), .LEN_W(LEN_W), .SEED(SEED), .GAP_VALID(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic smp_t mk(input logic v, input logic d, input logic s,
                               input logic dn, input logic b, input logic r);
      return {v, d, s, dn, b, r};
   endfunction

   // d is only meaningful while valid_out is high
   function automatic smp_t sample();
      return mk(bus.valid_out, bus.valid_out & bus.d_out, bus.sent_pulse,
                bus.done, bus.busy, bus.ready);
   endfunction

   // x^16+x^14+x^13+x^11+1, output bit is bit 0
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {^(s & 16'h002D), s[15:1]};
   endfunction

   // Expected samples from the first cycle after acceptance through the first idle cycle.
   task automatic build_exp(input logic [7:0] pat, input int len_raw, input int reps, input int gap);
      int len;
      len = (len_raw > PAT_W) ? PAT_W : len_raw;
      exp_q.delete();
      if (len > 0) begin
         for (int r = 0; r < reps; r++) begin
            for (int g = 0; g < gap; g++) begin
               exp_q.push_back(mk(1'b1, m_lfsr[0], 1'b0, 1'b0, 1'b1, 1'b0));
               m_lfsr = lfsr_next(m_lfsr);
            end
            for (int b = len - 1; b >= 0; b--)
               exp_q.push_back(mk(1'b1, pat[3'(b)], b == 0, 1'b0, 1'b1, 1'b0));
         end
      end
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
   endtask

   task automatic apply_load(input logic [7:0] pat, input int len, input int reps,
                             input int gap, input logic ab);
      bus.pat_in  = pat;
      bus.pat_len = LEN_W'(len);
      bus.rep_cnt = 8'(reps);
      bus.gap_len = 8'(gap);
      bus.load    = 1'b1;
      bus.abort   = ab;
      @(negedge clk);
      bus.load    = 1'b0;
      bus.abort   = 1'b0;
   endtask

   // Records n samples; junk loads/inputs (which must be ignored) are driven before junk_upto.
   task automatic collect(input int n, input int junk_upto, input int abort_at);
      obs_q.delete();
      for (int i = 0; i < n; i++) begin
         obs_q.push_back(sample());
         if (i < junk_upto) begin
            bus.load    = 1'($urandom_range(0, 1));
            bus.pat_in  = 8'($urandom);
            bus.pat_len = LEN_W'($urandom);
            bus.rep_cnt = 8'($urandom);
            bus.gap_len = 8'($urandom);
         end else begin
            bus.load = 1'b0;
         end
         bus.abort = (i == abort_at);
         @(negedge clk);
      end
      bus.load  = 1'b0;
      bus.abort = 1'b0;
   endtask

   task automatic test_reset();
      bus.load = 1'b0; bus.abort = 1'b0; bus.pat_in = '0;
      bus.pat_len = '0; bus.rep_cnt = '0; bus.gap_len = '0;
      #1 rst = 1'b0;
      #2;
      vec_cnt++;
      if (sample() !== mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)) begin
         err_cnt++; $display("FAIL reset_async got %b want 000001", sample());
      end
      repeat (2) @(negedge clk);
      vec_cnt++;
      if (sample() !== mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)) begin
         err_cnt++; $display("FAIL reset_held got %b want 000001", sample());
      end
      rst    = 1'b1;
      m_lfsr = SEED;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [7:0] want_d;
      want_d = 8'b1011_0011;
      build_exp(want_d, 8, 1, 0);
      apply_load(want_d, 8, 1, 0, 1'b0);
      collect(exp_q.size(), exp_q.size() - 1, -1);
      for (int i = 0; i < 8; i++) begin
         vec_cnt++;
         if (obs_q[i].vld !== 1'b1 || obs_q[i].d !== want_d[3'(7 - i)]) begin
            err_cnt++;
            $display("FAIL directed_bit%0d got vld=%b d=%b want vld=1 d=%b",
                     i + 1, obs_q[i].vld, obs_q[i].d, want_d[3'(7 - i)]);
         end
      end
      vec_cnt++;
      if ({obs_q[7].sent, obs_q[8].done, obs_q[8].ready, obs_q[9].ready} !== 4'b1101) begin
         err_cnt++;
         $display("FAIL directed_timing got sent8/done9/ready9/ready10=%b%b%b%b want 1101",
                  obs_q[7].sent, obs_q[8].done, obs_q[8].ready, obs_q[9].ready);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         vec_cnt++;
         if (obs_q[i] !== exp_q[i]) begin
            err_cnt++; $display("FAIL directed cyc%0d got %b want %b", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_gap_reps();
      int nv, ns;
      logic [15:0] seed_v;
      seed_v = SEED;
      build_exp(8'b0000_1101, 4, 3, 5);
      apply_load(8'b0000_1101, 4, 3, 5, 1'b0);
      collect(exp_q.size(), exp_q.size() - 1, -1);
      nv = 0; ns = 0;
      foreach (obs_q[i]) begin
         nv += int'(obs_q[i].vld);
         ns += int'(obs_q[i].sent);
      end
      vec_cnt++;
      if (nv != 27 || ns != 3) begin
         err_cnt++; $display("FAIL gap_counts got valid=%0d sent=%0d want 27/3", nv, ns);
      end
      for (int k = 0; k < 5; k++) begin
         vec_cnt++;
         if (obs_q[k].d !== seed_v[4'(k)]) begin
            err_cnt++; $display("FAIL gap_filler%0d got %b want %b", k, obs_q[k].d, seed_v[4'(k)]);
         end
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         vec_cnt++;
         if (obs_q[i] !== exp_q[i]) begin
            err_cnt++; $display("FAIL gap_reps cyc%0d got %b want %b", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_closed_loop();
      logic [3:0] sh;
      int nb, det, ns;
      build_exp(8'h0D, 4, 20, 0);
      apply_load(8'h0D, 4, 20, 0, 1'b0);
      collect(exp_q.size(), exp_q.size() - 1, -1);
      sh = '0; nb = 0; det = 0; ns = 0;
      foreach (obs_q[i]) begin
         ns += int'(obs_q[i].sent);
         if (obs_q[i].vld) begin
            sh = {sh[2:0], obs_q[i].d};
            nb++;
            if (nb >= 4 && sh == 4'b1101) det++;
         end
      end
      vec_cnt++;
      if (det != ns || ns != 20) begin
         err_cnt++; $display("FAIL closed_loop got detections=%0d sent=%0d want 20/20", det, ns);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         vec_cnt++;
         if (obs_q[i] !== exp_q[i]) begin
            err_cnt++; $display("FAIL closed_loop cyc%0d got %b want %b", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_degenerate();
      int lens[3] = '{0, 5, 15};
      int reps[3] = '{3, 0, 2};
      int gaps[3] = '{2, 2, 1};
      int nv, want_nv;
      logic [7:0] pat;
      for (int c = 0; c < 3; c++) begin
         pat = 8'($urandom);
         build_exp(pat, lens[c], reps[c], gaps[c]);
         apply_load(pat, lens[c], reps[c], gaps[c], 1'b0);
         collect(exp_q.size(), exp_q.size() - 1, -1);
         nv = 0;
         foreach (obs_q[i]) nv += int'(obs_q[i].vld);
         want_nv = (lens[c] == 0) ? 0 : reps[c] * (((lens[c] > PAT_W) ? PAT_W : lens[c]) + gaps[c]);
         vec_cnt++;
         if (nv != want_nv || (want_nv == 0 && obs_q[0].done !== 1'b1)) begin
            err_cnt++;
            $display("FAIL degenerate%0d got valid=%0d done1=%b want valid=%0d", c, nv, obs_q[0].done, want_nv);
         end
         for (int i = 0; i < exp_q.size(); i++) begin
            vec_cnt++;
            if (obs_q[i] !== exp_q[i]) begin
               err_cnt++; $display("FAIL degenerate%0d cyc%0d got %b want %b", c, i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_abort();
      int g;
      logic [7:0] pat;
      logic [15:0] saved;
      g = 3;
      pat = 8'($urandom);
      saved = m_lfsr;
      build_exp(pat, 8, 2, g);
      m_lfsr = saved;
      repeat (g) m_lfsr = lfsr_next(m_lfsr);
      exp_q = exp_q[0:g + 2];
      repeat (3) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      apply_load(pat, 8, 2, g, 1'b0);
      collect(g + 6, g + 2, g + 2);
      for (int i = 0; i < exp_q.size(); i++) begin
         vec_cnt++;
         if (obs_q[i] !== exp_q[i]) begin
            err_cnt++; $display("FAIL abort cyc%0d got %b want %b", i, obs_q[i], exp_q[i]);
         end
      end
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      vec_cnt++;
      if (sample() !== mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)) begin
         err_cnt++; $display("FAIL abort_idle got %b want 000001", sample());
      end
      pat = 8'($urandom);
      build_exp(pat, 6, 2, 4);
      apply_load(pat, 6, 2, 4, 1'b0);
      collect(exp_q.size(), exp_q.size() - 1, -1);
      for (int i = 0; i < exp_q.size(); i++) begin
         vec_cnt++;
         if (obs_q[i] !== exp_q[i]) begin
            err_cnt++; $display("FAIL after_abort cyc%0d got %b want %b", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] pat;
      apply_load(8'hA5, 8, 1, 10, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      vec_cnt++;
      if (sample() !== mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)) begin
         err_cnt++; $display("FAIL async_reset_mid_gap got %b want 000001", sample());
      end
      @(negedge clk);
      rst    = 1'b1;
      m_lfsr = SEED;
      @(negedge clk);
      pat = 8'($urandom);
      build_exp(pat, 4, 2, 5);
      apply_load(pat, 4, 2, 5, 1'b0);
      collect(exp_q.size(), exp_q.size() - 1, -1);
      vec_cnt++;
      if (obs_q[0].vld !== 1'b1 || obs_q[0].d !== 1'b1) begin
         err_cnt++; $display("FAIL reseed_first_filler got vld=%b d=%b want 1/1", obs_q[0].vld, obs_q[0].d);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         vec_cnt++;
         if (obs_q[i] !== exp_q[i]) begin
            err_cnt++; $display("FAIL after_reset cyc%0d got %b want %b", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] pat;
      int len, reps, gap;
      for (int t = 0; t < 12; t++) begin
         pat  = 8'($urandom);
         len  = int'($urandom_range(0, 15));
         reps = int'($urandom_range(0, 3));
         gap  = int'($urandom_range(0, 4));
         build_exp(pat, len, reps, gap);
         apply_load(pat, len, reps, gap, 1'($urandom_range(0, 1)));
         collect(exp_q.size(), exp_q.size() - 1, -1);
         for (int i = 0; i < exp_q.size(); i++) begin
            vec_cnt++;
            if (obs_q[i] !== exp_q[i]) begin
               err_cnt++;
               $display("FAIL random%0d (pat=%h len=%0d reps=%0d gap=%0d) cyc%0d got %b want %b",
                        t, pat, len, reps, gap, i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_gap_reps();
      test_closed_loop();
      test_degenerate();
      test_abort();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
